// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state/opcode encodings and width default for the memory arbiter
package mem_arbiter_pkg;

    localparam int MEM_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_XFER = 2'd1,
        ST_D_XFER  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_FETCH = 2'd1,
        OP_LOAD  = 2'd2,
        OP_STORE = 2'd3
    } mem_op_t;

    function automatic mem_op_t data_op(input logic we);
        return we ? OP_STORE : OP_LOAD;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory port
// Data port wins by default but yields to a pending fetch after DATA_STREAK grants in a row.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_STREAK = 2,
    parameter int MEM_W       = MEM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [MEM_W-1:0] if_adr,
    output logic [MEM_W-1:0] if_rdata,
    output logic             if_done,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [MEM_W-1:0] d_adr,
    input  logic [MEM_W-1:0] d_wdata,
    output logic [MEM_W-1:0] d_rdata,
    output logic             d_done,
    output logic             mem_req,
    output logic             mem_we,
    output logic [MEM_W-1:0] mem_adr,
    output logic [MEM_W-1:0] mem_wdata,
    input  logic [MEM_W-1:0] mem_rdata,
    input  logic             mem_done,
    output logic             busy
);

    localparam int              SW         = $clog2(DATA_STREAK + 2);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(DATA_STREAK);

    arb_state_t       r_state,     w_state_nxt;
    mem_op_t          r_op,        w_op_nxt;
    logic [SW-1:0]    r_streak,    w_streak_nxt;
    logic             r_mem_req,   w_mem_req_nxt;
    logic             r_mem_we,    w_mem_we_nxt;
    logic [MEM_W-1:0] r_mem_adr,   w_mem_adr_nxt;
    logic [MEM_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [MEM_W-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic [MEM_W-1:0] r_d_rdata,   w_d_rdata_nxt;
    logic             r_if_done,   w_if_done_nxt;
    logic             r_d_done,    w_d_done_nxt;
    logic             r_busy;

    logic             w_grant_ok;
    logic             w_pick_d;

    // No grant while a done pulse is out: a still-held req is not re-issued, and
    // the other port cannot slip in, which keeps the streak pattern D,D,IF intact.
    assign w_grant_ok = ~r_if_done & ~r_d_done;
    assign w_pick_d   = d_req & (~if_req | (r_streak < STREAK_MAX));

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_streak_nxt    = r_streak;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_adr_nxt   = r_mem_adr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_if_done_nxt   = 1'b0;
        w_d_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_ok) begin
                    if (w_pick_d) begin
                        w_state_nxt     = ST_D_XFER;
                        w_op_nxt        = data_op(d_we);
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = d_we;
                        w_mem_adr_nxt   = d_adr;
                        w_mem_wdata_nxt = d_wdata;
                        if (!if_req) begin
                            w_streak_nxt = '0;
                        end else if (r_streak != STREAK_MAX) begin
                            w_streak_nxt = r_streak + SW'(1);
                        end
                    end else if (if_req) begin
                        w_state_nxt   = ST_IF_XFER;
                        w_op_nxt      = OP_FETCH;
                        w_mem_req_nxt = 1'b1;
                        w_mem_we_nxt  = 1'b0;
                        w_mem_adr_nxt = if_adr;
                        w_streak_nxt  = '0;
                    end
                end
            end
            ST_IF_XFER: begin
                if (mem_done) begin
                    w_state_nxt    = ST_IDLE;
                    w_op_nxt       = OP_NONE;
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_if_rdata_nxt = mem_rdata;
                    w_if_done_nxt  = 1'b1;
                end
            end
            ST_D_XFER: begin
                if (mem_done) begin
                    w_state_nxt   = ST_IDLE;
                    w_op_nxt      = OP_NONE;
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    w_d_done_nxt  = 1'b1;
                    if (r_op == OP_LOAD) begin
                        w_d_rdata_nxt = mem_rdata;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_op_nxt      = OP_NONE;
                w_mem_req_nxt = 1'b0;
                w_mem_we_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NONE;
            r_streak    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_streak    <= w_streak_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_adr   <= w_mem_adr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_if_done   <= w_if_done_nxt;
            r_d_done    <= w_d_done_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_done   = r_if_done;
    assign d_rdata   = r_d_rdata;
    assign d_done    = r_d_done;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_adr   = r_mem_adr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_done;
    logic [31:0] if_adr, d_adr, d_wdata, mem_rdata;
    logic [31:0] if_rdata, d_rdata, mem_adr, mem_wdata;
    logic        if_done, d_done, mem_req, mem_we, busy;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        chk_wd;
    } xfer_t;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rdata;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_xfer = 0;
    int          n_if_done = 0;
    int          n_d_done = 0;
    int          lat = 1;
    bit          mem_hold = 0;
    bit          inj_done = 0;
    xfer_t       exp_q[$];
    logic [31:0] mem_img [logic [31:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // memory model: answers after 'lat' cycles of mem_req, scoreboards each transfer
    initial begin
        int    cnt;
        xfer_t e;
        cnt = 0;
        mem_done = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_done) begin
                mem_done = 1'b0;
                cnt = 0;
            end else if (inj_done) begin
                mem_done = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
                inj_done = 0;
            end else if (mem_req && !mem_hold) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_rdata = mem_rd(mem_adr);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_xfer", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("xfer_adr", mem_adr, e.adr);
                        chk("xfer_we", {31'b0, mem_we}, {31'b0, e.we});
                        if (e.chk_wd) chk("xfer_wdata", mem_wdata, e.wdata);
                    end
                    if (mem_we) mem_img[mem_adr] = mem_wdata;
                    n_xfer++;
                    mem_done = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // done pulses: exclusive and one cycle wide
    initial begin
        logic prev_if, prev_d;
        prev_if = 0;
        prev_d  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (if_done || d_done) chk("done_exclusive", {31'b0, if_done & d_done}, 32'd0);
                if (if_done) begin chk("if_done_width", {31'b0, prev_if}, 32'd0); n_if_done++; end
                if (d_done)  begin chk("d_done_width", {31'b0, prev_d}, 32'd0);  n_d_done++;  end
            end
            prev_if = if_done;
            prev_d  = d_done;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input bit want_d, output int cycles);
        bit ok;
        ok = 0;
        cycles = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (want_d ? d_done : if_done) begin
                ok = 1;
                cycles = i;
                break;
            end
        end
        chk("done_timeout", {31'b0, ok}, 32'd1);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        chk({nm, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        chk({nm, "_mem_adr"}, mem_adr, 32'd0);
        chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({nm, "_if_done"}, {31'b0, if_done}, 32'd0);
        chk({nm, "_d_done"}, {31'b0, d_done}, 32'd0);
        chk({nm, "_if_rdata"}, if_rdata, 32'd0);
        chk({nm, "_d_rdata"}, d_rdata, 32'd0);
        chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic run_one(input vec_t v);
        int n0, cyc;
        n0  = n_xfer;
        lat = v.lat;
        chk("pre_busy", {31'b0, busy}, 32'd0);
        exp_q.push_back('{we: v.is_d & v.we, adr: v.adr, wdata: v.wdata, chk_wd: v.is_d});
        if (v.is_d) begin
            d_req = 1; d_we = v.we; d_adr = v.adr; d_wdata = v.wdata;
        end else begin
            if_req = 1; if_adr = v.adr;
        end
        tick();
        chk("grant_mem_req", {31'b0, mem_req}, 32'd1);
        chk("grant_busy", {31'b0, busy}, 32'd1);
        chk("grant_mem_we", {31'b0, mem_we}, {31'b0, v.is_d & v.we});
        wait_done(v.is_d, cyc);
        chk("done_latency", cyc, v.lat - 1);
        d_req = 0;
        if_req = 0;
        chk(v.is_d ? "d_rdata" : "if_rdata", v.is_d ? d_rdata : if_rdata, v.exp_rdata);
        chk("done_mem_req", {31'b0, mem_req}, 32'd0);
        chk("done_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("done_pulse_end", {31'b0, if_done | d_done}, 32'd0);
        tick();
        chk("one_xfer", n_xfer, n0 + 1);
    endtask

    vec_t vecs[8];

    initial begin
        int n0, nif0, nd0, cnt, cyc;
        vecs[0] = '{is_d: 0, we: 0, adr: 32'h10,   wdata: 0,            lat: 3, exp_rdata: 32'h0000_0013};
        vecs[1] = '{is_d: 1, we: 1, adr: 32'h100,  wdata: 32'hDEADBEEF, lat: 1, exp_rdata: 32'h0000_0000};
        vecs[2] = '{is_d: 1, we: 0, adr: 32'h100,  wdata: 32'h1,        lat: 2, exp_rdata: 32'hDEADBEEF};
        vecs[3] = '{is_d: 0, we: 0, adr: 32'h2000, wdata: 0,            lat: 1, exp_rdata: 32'hC0DE_2000};
        vecs[4] = '{is_d: 1, we: 0, adr: 32'h44,   wdata: 32'h0,        lat: 5, exp_rdata: 32'hC0DE_0044};
        vecs[5] = '{is_d: 1, we: 1, adr: 32'h44,   wdata: 32'h12345678, lat: 2, exp_rdata: 32'hC0DE_0044};
        vecs[6] = '{is_d: 0, we: 0, adr: 32'h44,   wdata: 0,            lat: 1, exp_rdata: 32'h1234_5678};
        vecs[7] = '{is_d: 1, we: 0, adr: 32'h0,    wdata: 32'h0,        lat: 1, exp_rdata: 32'hC0DE_0000};
        mem_img[32'h10] = 32'h0000_0013;

        rst = 1; if_req = 0; if_adr = 0; d_req = 0; d_we = 0; d_adr = 0; d_wdata = 0;
        tick(); tick();
        check_all_zero("reset");
        rst = 0;
        tick();

        foreach (vecs[i]) run_one(vecs[i]);

        // latched address must ignore requester changes after grant
        lat = 4;
        exp_q.push_back('{we: 0, adr: 32'h200, wdata: 32'h0, chk_wd: 1});
        d_req = 1; d_we = 0; d_adr = 32'h200; d_wdata = 32'h0;
        tick();
        d_adr = 32'h300; d_we = 1; d_wdata = 32'hFFFF_0000;
        cnt = 0;
        while (!d_done && cnt < 40) begin
            if (mem_req) begin
                chk("hold_mem_adr", mem_adr, 32'h200);
                chk("hold_mem_we", {31'b0, mem_we}, 32'd0);
            end
            tick();
            cnt++;
        end
        chk("hold_done_seen", {31'b0, d_done}, 32'd1);
        d_req = 0;
        chk("hold_d_rdata", d_rdata, 32'hC0DE_0200);
        tick(); tick();

        // both ports held: data gets DATA_STREAK grants, then a fetch
        lat = 1;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back('{we: 0, adr: 32'h500, wdata: 32'h0, chk_wd: 1});
            exp_q.push_back('{we: 0, adr: 32'h500, wdata: 32'h0, chk_wd: 1});
            exp_q.push_back('{we: 0, adr: 32'h600, wdata: 32'h0, chk_wd: 0});
        end
        n0 = n_xfer; nif0 = n_if_done; nd0 = n_d_done;
        d_req = 1; d_we = 0; d_adr = 32'h500; d_wdata = 0;
        if_req = 1; if_adr = 32'h600;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (if_done || d_done) cnt++;
            if (cnt == 6) break;
        end
        d_req = 0; if_req = 0;
        tick(); tick(); tick();
        chk("streak_xfers", n_xfer, n0 + 6);
        chk("streak_q_empty", exp_q.size(), 32'd0);
        chk("streak_if_dones", n_if_done, nif0 + 2);
        chk("streak_d_dones", n_d_done, nd0 + 4);

        // back-to-back fetch with req held through done
        lat = 2;
        n0 = n_xfer;
        exp_q.push_back('{we: 0, adr: 32'h80, wdata: 32'h0, chk_wd: 0});
        exp_q.push_back('{we: 0, adr: 32'h80, wdata: 32'h0, chk_wd: 0});
        if_req = 1; if_adr = 32'h80;
        tick();
        wait_done(0, cyc);
        chk("b2b_done_mem_req", {31'b0, mem_req}, 32'd0);
        tick();
        chk("b2b_no_dup", {31'b0, mem_req}, 32'd0);
        tick();
        chk("b2b_regrant", {31'b0, mem_req}, 32'd1);
        if_req = 0;
        wait_done(0, cyc);
        tick(); tick();
        chk("b2b_xfers", n_xfer, n0 + 2);
        chk("b2b_if_rdata", if_rdata, 32'hC0DE_0080);

        // reset mid-transfer, then a stray mem_done
        mem_hold = 1;
        nd0 = n_d_done;
        d_req = 1; d_we = 1; d_adr = 32'h700; d_wdata = 32'hA5A5_5A5A;
        tick();
        chk("rst_seq_granted", {31'b0, mem_req}, 32'd1);
        tick(); tick();
        rst = 1;
        tick();
        rst = 0; d_req = 0;
        check_all_zero("midrst");
        tick(); tick();
        inj_done = 1;
        for (int i = 0; i < 4; i++) tick();
        check_all_zero("late_done");
        chk("late_no_d_done", n_d_done, nd0);
        mem_hold = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
